// File: rtl/spi_pkg.sv
// Shared SPI definitions: engine states, default width and mode encodings.
// Used by both the slave engine and the master controller.
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizes the external SPI pins into clk and detects SCK edges
// relative to the idle polarity (leading = leaving cpol, trailing = returning).
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cpol,
    input  logic sck_in,
    input  logic ss_n_in,
    input  logic mosi_in,
    output logic s_sck,
    output logic s_ss_n,
    output logic s_mosi,
    output logic lead_edge,
    output logic trail_edge
);

    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] ss_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sck_d;

    // Synchronizer chains plus the delayed SCK copy used for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q  <= {SYNC_STAGES{cpol}};
            ss_q   <= '1;
            mosi_q <= '0;
            sck_d  <= cpol;
        end else begin
            sck_q  <= {sck_q[SYNC_STAGES-2:0], sck_in};
            ss_q   <= {ss_q[SYNC_STAGES-2:0], ss_n_in};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi_in};
            sck_d  <= s_sck;
        end
    end

    assign s_sck  = sck_q[SYNC_STAGES-1];
    assign s_ss_n = ss_q[SYNC_STAGES-1];
    assign s_mosi = mosi_q[SYNC_STAGES-1];

    assign lead_edge  = (s_sck != sck_d) && (sck_d == cpol);
    assign trail_edge = (s_sck != sck_d) && (s_sck == cpol);

endmodule

// File: rtl/spi_slave_engine.sv
// Slave-side SPI shift engine: shifts MOSI in and the buffered tx byte out,
// raising a sticky spif with the received byte at the end of each transfer.
module spi_slave_engine
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spe,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsbfe,
    input  logic              sck_in,
    input  logic              ss_n_in,
    input  logic              mosi_in,
    output logic              miso_out,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic [DATA_W-1:0] rx_data,
    output logic              spif,
    input  logic              spif_clr,
    output logic              wcol,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] txbuf;
    logic [DATA_W-1:0] tx_next;
    logic              s_sck;
    logic              s_ss_n;
    logic              s_mosi;
    logic              lead_edge;
    logic              trail_edge;
    logic              selected;
    logic              sample_edge;
    logic              shift_edge;
    logic              tx_accept;
    logic              last_sample;

    spi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .cpol      (cpol),
        .sck_in    (sck_in),
        .ss_n_in   (ss_n_in),
        .mosi_in   (mosi_in),
        .s_sck     (s_sck),
        .s_ss_n    (s_ss_n),
        .s_mosi    (s_mosi),
        .lead_edge (lead_edge),
        .trail_edge(trail_edge)
    );

    function automatic logic out_bit(input logic lsb,
                                     input logic [DATA_W-1:0] v);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    assign selected    = ~s_ss_n;
    assign miso_oe     = spe & selected;
    assign busy        = (state != IDLE);
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge : trail_edge;
    assign tx_accept   = tx_load & (state != SHIFT);
    assign tx_next     = tx_accept ? tx_data : txbuf;
    assign last_sample = (cnt == CNT_W'(DATA_W - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; deselect or spe=0 always falls back to IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:
                if (spe && selected) state_nxt = SHIFT;
            SHIFT:
                if (!spe || !selected)            state_nxt = IDLE;
                else if (sample_edge && last_sample) state_nxt = DONE;
            DONE:
                state_nxt = (spe && selected) ? SHIFT : IDLE;
            default:
                state_nxt = IDLE;
        endcase
    end

    // Datapath: tx buffer, shift register, bit counter, MISO and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            txbuf    <= '0;
            sreg     <= '0;
            cnt      <= '0;
            miso_out <= 1'b0;
            rx_data  <= '0;
            spif     <= 1'b0;
            wcol     <= 1'b0;
        end else begin
            if (tx_accept) begin
                txbuf <= tx_data;
                wcol  <= 1'b0;
            end else if (tx_load) begin
                wcol  <= 1'b1;
            end
            if (spif_clr) spif <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt      <= '0;
                    sreg     <= tx_next;
                    miso_out <= (state_nxt == SHIFT) && !cpha
                              ? out_bit(lsbfe, tx_next) : 1'b0;
                end
                SHIFT: begin
                    if (state_nxt == IDLE) begin
                        cnt <= '0;
                    end else begin
                        if (sample_edge) begin
                            cnt  <= cnt + 1'b1;
                            sreg <= lsbfe
                                  ? {s_mosi, sreg[DATA_W-1:1]}
                                  : {sreg[DATA_W-2:0], s_mosi};
                        end
                        // Idempotent when no sample has happened since
                        // the last load, so the post-byte edge is a no-op
                        if (shift_edge) miso_out <= out_bit(lsbfe, sreg);
                    end
                end
                DONE: begin
                    rx_data <= sreg;
                    spif    <= 1'b1;
                    cnt     <= '0;
                    sreg    <= tx_next;
                    if (!cpha && state_nxt == SHIFT)
                        miso_out <= out_bit(lsbfe, tx_next);
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_engine.sv
// Directed bench for spi_slave_engine: a bit-banged master drives the pins
// at clk/16 while vectors and corner-case sequences check the slave's outputs.
module tb_spi_slave_engine;
    import spi_pkg::*;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int H    = 8;

    typedef struct {
        logic       cp;
        logic       ch;
        logic       lf;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         spe;
    logic         cpol;
    logic         cpha;
    logic         lsbfe;
    logic         sck_in;
    logic         ss_n_in;
    logic         mosi_in;
    logic         miso_out;
    logic         miso_oe;
    logic [W-1:0] tx_data;
    logic         tx_load;
    logic [W-1:0] rx_data;
    logic         spif;
    logic         spif_clr;
    logic         wcol;
    logic         busy;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         t_edge = 0;
    int         t_spif = -1;
    int         spif_rises = 0;
    int         rises0;
    logic       spif_q = 1'b0;
    logic [7:0] miso_cap;
    vec_t       vecs[6];

    spi_slave_engine #(
        .DATA_W     (W),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .spe     (spe),
        .cpol    (cpol),
        .cpha    (cpha),
        .lsbfe   (lsbfe),
        .sck_in  (sck_in),
        .ss_n_in (ss_n_in),
        .mosi_in (mosi_in),
        .miso_out(miso_out),
        .miso_oe (miso_oe),
        .tx_data (tx_data),
        .tx_load (tx_load),
        .rx_data (rx_data),
        .spif    (spif),
        .spif_clr(spif_clr),
        .wcol    (wcol),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (spif && !spif_q) begin
            t_spif = cyc;
            spif_rises++;
        end
        spif_q = spif;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_mode(input logic cp, input logic ch, input logic lf);
        cpol   = cp;
        cpha   = ch;
        lsbfe  = lf;
        sck_in = cp;
        tick(10);
    endtask

    task automatic load(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        tick(1);
    endtask

    task automatic clr();
        spif_clr = 1'b1;
        tick(1);
        spif_clr = 1'b0;
        tick(1);
    endtask

    task automatic sel();
        ss_n_in = 1'b0;
        tick(H);
    endtask

    task automatic desel();
        tick(H);
        ss_n_in = 1'b1;
        tick(H);
    endtask

    task automatic post_edge(input bit fin, input bit do_load,
                             input logic [7:0] lv, input bit do_clr);
        for (int j = 1; j <= H; j++) begin
            @(negedge clk);
            tx_load  = 1'b0;
            spif_clr = 1'b0;
            if (fin && j == SYNC + 1) begin
                if (do_load) begin
                    tx_data = lv;
                    tx_load = 1'b1;
                end
                if (do_clr) spif_clr = 1'b1;
            end
        end
        tx_load  = 1'b0;
        spif_clr = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] mo, input int first,
                        input int last, input bit do_load,
                        input logic [7:0] lv, input bit do_clr);
        for (int i = first; i <= last; i++) begin
            int b;
            b = lsbfe ? i : 7 - i;
            if (!cpha) begin
                mosi_in = mo[b];
                tick(H);
                miso_cap[b] = miso_out;
                sck_in = ~cpol;
                if (i == last) t_edge = cyc;
                post_edge(i == last, do_load, lv, do_clr);
                sck_in = cpol;
            end else begin
                sck_in  = ~cpol;
                mosi_in = mo[b];
                tick(H);
                miso_cap[b] = miso_out;
                sck_in = cpol;
                if (i == last) t_edge = cyc;
                post_edge(i == last, do_load, lv, do_clr);
            end
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'hC3, 8'h5A, 8'hC3, 8'h5A};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 8'h96, 8'h69, 8'h96, 8'h69};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 8'h01, 8'h80, 8'h01, 8'h80};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h80, 8'h01, 8'h80, 8'h01};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 8'hF0, 8'h0F, 8'hF0, 8'h0F};

        rst      = 1'b1;
        spe      = 1'b1;
        cpol     = 1'b0;
        cpha     = 1'b0;
        lsbfe    = 1'b0;
        sck_in   = 1'b0;
        ss_n_in  = 1'b1;
        mosi_in  = 1'b0;
        tx_data  = '0;
        tx_load  = 1'b0;
        spif_clr = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst miso_out", miso_out, 0);
        check("rst miso_oe", miso_oe, 0);
        check("rst rx_data", rx_data, 0);
        check("rst spif", spif, 0);
        check("rst wcol", wcol, 0);
        check("rst busy", busy, 0);

        foreach (vecs[k]) begin
            set_mode(vecs[k].cp, vecs[k].ch, vecs[k].lf);
            load(vecs[k].tx);
            clr();
            sel();
            check($sformatf("v%0d miso_oe", k), miso_oe, 1);
            miso_cap = '0;
            xfer(vecs[k].mo, 0, 7, 0, 8'h00, 0);
            desel();
            check($sformatf("v%0d miso", k), miso_cap, vecs[k].exp_miso);
            check($sformatf("v%0d rx", k), rx_data, vecs[k].exp_rx);
            check($sformatf("v%0d spif", k), spif, 1);
            check($sformatf("v%0d spif lat", k), t_spif - t_edge, SYNC + 2);
        end

        // Mode 3, LSB first, back-to-back bytes with a load during DONE
        set_mode(1'b1, 1'b1, 1'b1);
        load(8'h81);
        clr();
        rises0 = spif_rises;
        sel();
        miso_cap = '0;
        xfer(8'h12, 0, 7, 1, 8'h7E, 0);
        check("b2b miso0", miso_cap, 8'h81);
        check("b2b rx0", rx_data, 8'h12);
        check("b2b wcol", wcol, 0);
        clr();
        miso_cap = '0;
        xfer(8'h34, 0, 7, 0, 8'h00, 0);
        desel();
        check("b2b miso1", miso_cap, 8'h7E);
        check("b2b rx1", rx_data, 8'h34);
        check("b2b spif rises", spif_rises - rises0, 2);

        // Abort after 5 samples, then a clean full byte
        set_mode(1'b0, 1'b0, 1'b0);
        load(8'hC3);
        clr();
        sel();
        miso_cap = '0;
        xfer(8'hF0, 0, 4, 0, 8'h00, 0);
        desel();
        check("abort spif", spif, 0);
        check("abort rx", rx_data, 8'h34);
        check("abort oe", miso_oe, 0);
        check("abort busy", busy, 0);
        sel();
        check("after abort miso first", miso_out, 1);
        miso_cap = '0;
        xfer(8'h55, 0, 7, 0, 8'h00, 0);
        desel();
        check("after abort miso", miso_cap, 8'hC3);
        check("after abort rx", rx_data, 8'h55);
        check("after abort spif", spif, 1);

        // Write collision mid-byte
        load(8'h00);
        sel();
        miso_cap = '0;
        xfer(8'h3C, 0, 3, 0, 8'h00, 0);
        tx_data = 8'hFF;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        tick(1);
        check("wcol set", wcol, 1);
        xfer(8'h3C, 4, 7, 0, 8'h00, 0);
        desel();
        check("wcol miso", miso_cap, 8'h00);
        check("wcol rx", rx_data, 8'h3C);
        load(8'h11);
        check("wcol cleared", wcol, 0);

        // spif_clr in the DONE cycle loses to the set
        clr();
        sel();
        miso_cap = '0;
        xfer(8'hE7, 0, 7, 0, 8'h00, 1);
        check("clr@done spif", spif, 1);
        check("clr@done rx", rx_data, 8'hE7);
        check("clr@done miso", miso_cap, 8'h11);
        spif_clr = 1'b1;
        tick(1);
        spif_clr = 1'b0;
        check("clr next spif", spif, 0);
        desel();

        // Reset mid-byte with a pending collision, then spe=0 with SCK running
        load(8'hC3);
        sel();
        miso_cap = '0;
        xfer(8'hAA, 0, 3, 0, 8'h00, 0);
        tx_data = 8'h5A;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        rst = 1'b1;
        spe = 1'b0;
        tick(1);
        rst = 1'b0;
        repeat (3) begin
            sck_in = ~cpol;
            tick(H);
            sck_in = cpol;
            tick(H);
        end
        check("rst2 miso_out", miso_out, 0);
        check("rst2 miso_oe", miso_oe, 0);
        check("rst2 busy", busy, 0);
        check("rst2 spif", spif, 0);
        check("rst2 wcol", wcol, 0);
        check("rst2 rx", rx_data, 0);

        // Glitches while deselected must not disturb the next byte
        ss_n_in = 1'b1;
        spe = 1'b1;
        tick(H);
        repeat (3) begin
            sck_in = ~cpol;
            tick(H);
            sck_in = cpol;
            tick(H);
        end
        check("glitch busy", busy, 0);
        load(8'hA5);
        sel();
        miso_cap = '0;
        xfer(8'h96, 0, 7, 0, 8'h00, 0);
        desel();
        check("post rst miso", miso_cap, 8'hA5);
        check("post rst rx", rx_data, 8'h96);
        check("post rst spif", spif, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_engine.md
Name: spi_slave_engine

Overview:
Slave-side SPI shift engine, the responder counterpart to the master/slave controller. An external master drives SCK, SS_n and MOSI, and this block samples them in the system clock domain. It shifts a byte in from MOSI while shifting the preloaded transmit byte out on MISO. On completion it raises SPIF and presents the received byte for the SPDR.

Parameters:
DATA_W, 8, shift/data width in bits
SYNC_STAGES, 2, flip-flop stages on each asynchronous input (sck_in, ss_n_in, mosi_in); minimum 2

Ports:
clk  in  1  system clock; the only clock in the block
rst  in  1  reset, synchronous, active-high
spe  in  1  SPI enable from SPCR; 0 forces IDLE
cpol  in  1  clock polarity: idle level of SCK
cpha  in  1  clock phase: 0 = sample on leading edge, 1 = sample on trailing edge
lsbfe  in  1  1 = LSB first, 0 = MSB first
sck_in  in  1  external SCK, asynchronous
ss_n_in  in  1  external slave select, active low, asynchronous
mosi_in  in  1  external MOSI, asynchronous
miso_out  out  1  serial data to master
miso_oe  out  1  MISO output enable; equals spe & selected
tx_data  in  DATA_W  byte to transmit (SPDR write value)
tx_load  in  1  1-cycle pulse: write tx_data into the tx buffer
rx_data  out  DATA_W  last complete received byte
spif  out  1  transfer-complete flag, sticky
spif_clr  in  1  1-cycle pulse: clear spif
wcol  out  1  write-collision flag, sticky until the next accepted tx_load
busy  out  1  1 while in SHIFT or DONE

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; miso_out=0, miso_oe=0, rx_data=0, spif=0, wcol=0, busy=0.
- Tx buffer and bit counter clear to 0. Synchronizer flops reset to the idle levels (sck=cpol, ss_n=1, mosi=0).
- Synchronized signals: s_sck, s_ss_n, s_mosi.
- Edge detect compares s_sck with its registered copy.
  - leading edge: the edge leaving the cpol level; trailing edge: the edge returning to it.
  - sample edge = leading if cpha=0, else trailing; shift edge = the other one.
  - Latency from a pin transition to internal action: SYNC_STAGES+1 clk cycles.
  - Legal operation requires f_clk >= 8 x f_SCK.
- selected = ~s_ss_n.
- States:
  - IDLE: not selected, or spe=0. Shift register is loaded from the tx buffer every cycle.
  - SHIFT: selected.
    - On entry with cpha=0, miso_out = first tx bit immediately (bit 7, or bit 0 if lsbfe).
    - With cpha=1, the first bit is driven on the first leading (shift) edge.
    - Each sample edge: shift s_mosi into the register and increment the counter.
    - Each shift edge: advance miso_out to the next bit. The shift edge that follows the final sample edge does not advance.
  - DONE: exactly 1 cycle, entered on the DATA_W-th sample edge.
    - rx_data <= assembled byte, with bit order per lsbfe.
    - spif <= 1.
    - Counter <= 0; shift register reloads from the tx buffer.
    - Next state: SHIFT if still selected (back-to-back bytes), else IDLE.
- Transitions:
  - IDLE -> SHIFT when spe & selected.
  - SHIFT -> IDLE when deselected before DATA_W samples (abort).
  - Any state -> IDLE when spe=0.
- Abort (SS_n high mid-byte or spe dropped): counter=0, partial data discarded, rx_data and spif unchanged, miso_oe=0 on the same cycle.
- tx_load:
  - In IDLE or DONE: the tx buffer is written and wcol is cleared.
  - In SHIFT: the write is ignored and wcol is set to 1.
  - A load in DONE is used for the next byte.
- spif:
  - Set by DONE, cleared by spif_clr.
  - Set and clear in the same cycle: set wins.
  - A second completion while spif=1 overwrites rx_data; no overrun flag.
- mode changes (cpol, cpha, lsbfe) while busy: undefined; software must change them only in IDLE.
- A glitch on SCK while deselected is ignored: no counter change.

Decomposition:
- Shared package spi_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - DATA_W default constant.
  - SPI mode encodings (MODE0..MODE3 as {cpol, cpha}), shared with the master controller.
- One sub-module, spi_sync_edge:
  - SYNC_STAGES synchronizer on sck/ss_n/mosi.
  - Registered-SCK edge detector producing lead_edge and trail_edge pulses (cpol-aware).
- FSM, counter and shift register stay in spi_slave_engine.

Test Plan:
- Mode 0, lsbfe=0, tx_load 0x3C, master sends 0xA5 at clk/16 -> MISO bits 0,0,1,1,1,1,0,0; rx_data=0xA5; spif=1 exactly SYNC_STAGES+2 cycles after the 8th rising SCK.
- Mode 3, lsbfe=1, tx 0x81 then tx_load 0x7E during DONE, master sends 0x12, 0x34 with SS held low -> MISO LSB-first 0x81 then 0x7E; rx_data 0x12 then 0x34; two spif set events.
- SS_n raised after 5 sample edges, then a full 0x55 transfer -> no spif after the abort; the next transfer gives rx_data=0x55 and a correct first MISO bit.
- tx_load 0xFF mid-byte while tx buffer=0x00 -> wcol=1; MISO carries 0x00; the next IDLE tx_load clears wcol.
- spif_clr asserted in the same cycle as DONE -> spif=1; spif_clr the next cycle -> spif=0.
- rst=1 mid-transfer (bit 4), then spe=0 with SCK toggling -> all outputs 0, state IDLE, no counter advance.
